// File: rtl/n8_pad_responder.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// n8_pad_responder
//
// Pad-side end of the N8 serial pad link. On a host latch the button levels are
// captured (active-low) into an 8-bit shift register. Each host pulse then
// shifts the next bit onto data_out. Used as an on-board pad emulator and as a
// loopback target for n8_driver bring-up.
//
// Optional feature: define N8_TURBO_EN to enable turbo on the A/B buttons.
// Without it, turbo_en is ignored and no turbo logic is built.
//
// Parameters
//   SYNC_STAGES   flops in each latch/pulse synchroniser (>=2)
//   TURBO_FRAMES  latch frames per turbo half-period (>=1, N8_TURBO_EN only)
//
// Ports
//   clk         system clock
//   reset       asynchronous, active-low reset
//   latch       host latch, asynchronous to clk, active-high
//   pulse       host shift clock, asynchronous to clk, bit advances on rise
//   buttons     1=pressed: [0]A [1]B [2]Select [3]Start [4]Up [5]Down
//               [6]Left [7]Right
//   turbo_en    [0] turbo on A, [1] turbo on B
//   data_out    serial bit to host, 0=pressed
//   busy        high while bits are being shifted out
//   frame_tick  one-cycle strobe on synchronised latch falling edge
//   bit_idx     index of bit currently on data_out (8 = past the end)
// ----------------------------------------------------------------------------
module n8_pad_responder #(
    parameter int SYNC_STAGES  = 2,
    parameter int TURBO_FRAMES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       latch,
    input  logic       pulse,
    input  logic [7:0] buttons,
    input  logic [1:0] turbo_en,
    output logic       data_out,
    output logic       busy,
    output logic       frame_tick,
    output logic [3:0] bit_idx
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_DONE
    } state_t;

    // ------------------------------------------------------------------
    // Synchronisers and edge detection for the two host strobes
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] latch_sync_reg;
    logic [SYNC_STAGES-1:0] pulse_sync_reg;
    logic                   latch_d_reg;
    logic                   pulse_d_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            latch_sync_reg <= '0;
            pulse_sync_reg <= '0;
            latch_d_reg    <= 1'b0;
            pulse_d_reg    <= 1'b0;
        end else begin
            latch_sync_reg <= {latch_sync_reg[SYNC_STAGES-2:0], latch};
            pulse_sync_reg <= {pulse_sync_reg[SYNC_STAGES-2:0], pulse};
            latch_d_reg    <= latch_sync_reg[SYNC_STAGES-1];
            pulse_d_reg    <= pulse_sync_reg[SYNC_STAGES-1];
        end
    end

    logic latch_s;
    logic pulse_s;
    logic latch_rise;
    logic latch_fall;
    logic pulse_rise;

    assign latch_s    = latch_sync_reg[SYNC_STAGES-1];
    assign pulse_s    = pulse_sync_reg[SYNC_STAGES-1];
    assign latch_rise = latch_s & ~latch_d_reg;
    assign latch_fall = ~latch_s & latch_d_reg;
    assign pulse_rise = pulse_s & ~pulse_d_reg;

    // ------------------------------------------------------------------
    // Effective buttons (turbo masking of A/B when enabled)
    // ------------------------------------------------------------------
    logic [7:0] eff_buttons;

`ifdef N8_TURBO_EN
    localparam int CNT_W = (TURBO_FRAMES > 1) ? $clog2(TURBO_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TURBO_FRAMES - 1);

    logic [CNT_W-1:0] frame_cnt_reg;
    logic             phase_reg;

    // Phase starts at 0 so a held turbo button is reported pressed first.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_cnt_reg <= '0;
            phase_reg     <= 1'b0;
        end else if (frame_tick) begin
            if (frame_cnt_reg == CNT_LAST) begin
                frame_cnt_reg <= '0;
                phase_reg     <= ~phase_reg;
            end else begin
                frame_cnt_reg <= frame_cnt_reg + 1'b1;
            end
        end
    end

    assign eff_buttons = {buttons[7:2], buttons[1:0] & ~(turbo_en & {2{phase_reg}})};
`else
    logic unused_turbo;
    assign unused_turbo = ^turbo_en;
    assign eff_buttons  = buttons;
`endif

    // ------------------------------------------------------------------
    // Frame FSM with registered outputs
    // ------------------------------------------------------------------
    state_t     state_reg;
    logic [7:0] sreg_reg;
    logic [7:0] load_val;
    logic [7:0] shifted;

    assign load_val = ~eff_buttons;
    assign shifted  = {1'b0, sreg_reg[7:1]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= ST_IDLE;
            sreg_reg   <= 8'hFF;
            data_out   <= 1'b1;
            busy       <= 1'b0;
            frame_tick <= 1'b0;
            bit_idx    <= 4'd0;
        end else begin
            frame_tick <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    data_out <= 1'b1;
                    if (latch_rise) begin
                        state_reg <= ST_LOAD;
                        sreg_reg  <= load_val;
                        data_out  <= load_val[0];
                        bit_idx   <= 4'd0;
                    end
                end
                ST_LOAD: begin
                    // Pulses are ignored here; the register tracks the
                    // buttons until the latch drops, then freezes.
                    if (latch_fall) begin
                        state_reg  <= ST_SHIFT;
                        busy       <= 1'b1;
                        frame_tick <= 1'b1;
                    end else begin
                        sreg_reg <= load_val;
                        data_out <= load_val[0];
                    end
                end
                ST_SHIFT: begin
                    // A latch rise aborts the frame and takes priority over
                    // a simultaneous pulse rise.
                    if (latch_rise) begin
                        state_reg <= ST_LOAD;
                        sreg_reg  <= load_val;
                        data_out  <= load_val[0];
                        bit_idx   <= 4'd0;
                        busy      <= 1'b0;
                    end else if (pulse_rise) begin
                        sreg_reg <= shifted;
                        if (bit_idx == 4'd7) begin
                            state_reg <= ST_DONE;
                            busy      <= 1'b0;
                            data_out  <= 1'b0;
                            bit_idx   <= 4'd8;
                        end else begin
                            data_out <= shifted[0];
                            bit_idx  <= bit_idx + 4'd1;
                        end
                    end
                end
                ST_DONE: begin
                    data_out <= 1'b0;
                    bit_idx  <= 4'd8;
                    if (latch_rise) begin
                        state_reg <= ST_LOAD;
                        sreg_reg  <= load_val;
                        data_out  <= load_val[0];
                        bit_idx   <= 4'd0;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    data_out  <= 1'b1;
                    busy      <= 1'b0;
                    bit_idx   <= 4'd0;
                end
            endcase
        end
    end

endmodule
